// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the core data-memory port.
// Stores to TXDATA push bytes into a small FIFO, and a serializer shifts each
// byte out LSB first. Loads return status or control in the same cycle.
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      synchronous active-high reset
//   MemWrite_i   store strobe
//   MemRead_i    load strobe
//   Address_i    byte address; [31:4] selects the window, [3:2] selects the register
//   WriteData_i  store data
//   sel_o        address hits the window (combinational)
//   ReadData_o   register read data (combinational; 0 unless a load hits)
//   tx_o         serial line, registered, idle high
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        MemWrite_i,
   input  logic        MemRead_i,
   input  logic [31:0] Address_i,
   input  logic [31:0] WriteData_i,
   output logic        sel_o,
   output logic [31:0] ReadData_o,
   output logic        tx_o
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_CTRL   = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } state_e;

   // Registered state
   state_e             state_q,    state_d;
   logic [BAUD_W-1:0]  baud_q,     baud_d;
   logic [2:0]         bit_q,      bit_d;
   logic [7:0]         shift_q,    shift_d;
   logic               tx_q,       tx_d;
   logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
   logic [CNT_W-1:0]   count_q,    count_d;
   logic               overflow_q, overflow_d;
   logic               enable_q,   enable_d;
   logic [7:0]         fifo_mem_q [FIFO_DEPTH];

   // Decode and handshake signals
   logic        hit_c;
   logic [1:0]  off_c;
   logic        wr_c;
   logic        rd_c;
   logic        push_req_c;
   logic        push_ok_c;
   logic        drop_c;
   logic        pop_c;
   logic        full_c;
   logic        empty_c;
   logic        baud_wrap_c;
   logic [31:0] status_c;
   logic        unused_c;

   // Address decode; the low two address bits are don't-care
   assign hit_c      = (Address_i[31:4] == BASE_ADDR[31:4]);
   assign off_c      = Address_i[3:2];
   assign wr_c       = hit_c & MemWrite_i;
   assign rd_c       = hit_c & MemRead_i;
   assign sel_o      = hit_c;

   assign full_c     = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty_c    = (count_q == '0);

   // The serializer only pops from IDLE, so a pop frees a slot in the same cycle
   assign pop_c      = (state_q == ST_IDLE) & enable_q & ~empty_c;
   assign push_req_c = wr_c & (off_c == OFF_TXDATA);
   assign push_ok_c  = push_req_c & (~full_c | pop_c);
   assign drop_c     = push_req_c & ~push_ok_c;

   assign baud_wrap_c = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

   assign status_c = {16'h0000, 8'(count_q), 4'h0,
                      overflow_q, empty_c, full_c, (state_q != ST_IDLE)};

   assign tx_o = tx_q;

   // Store-data and address bits with no register behind them
   assign unused_c = ^{Address_i[1:0], WriteData_i[31:8]};

   // Load data mux; zero outside a hitting load
   always_comb begin
      ReadData_o = '0;
      if (rd_c) begin
         case (off_c)
            OFF_STATUS: ReadData_o = status_c;
            OFF_CTRL:   ReadData_o = {31'h0, enable_q};
            default:    ReadData_o = '0;
         endcase
      end
   end

   // FIFO pointers, occupancy and control/status register updates
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      enable_d   = enable_q;

      if (push_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)     rd_ptr_d = rd_ptr_q + PTR_W'(1);

      case ({push_ok_c, pop_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // Clear first so that a same-cycle drop wins
      if (wr_c && (off_c == OFF_STATUS) && WriteData_i[3]) overflow_d = 1'b0;
      if (drop_c)                                          overflow_d = 1'b1;

      if (wr_c && (off_c == OFF_CTRL)) enable_d = WriteData_i[0];
   end

   // Serializer next-state and line level
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = 1'b1;

      case (state_q)
         ST_IDLE: begin
            tx_d   = 1'b1;
            baud_d = '0;
            if (pop_c) begin
               shift_d = fifo_mem_q[rd_ptr_q];
               bit_d   = '0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            tx_d = 1'b0;
            if (baud_wrap_c) begin
               baud_d  = '0;
               state_d = ST_DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         ST_DATA: begin
            tx_d = shift_q[0];
            if (baud_wrap_c) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = ST_STOP;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         ST_STOP: begin
            tx_d = 1'b1;
            if (baud_wrap_c) begin
               baud_d  = '0;
               state_d = ST_IDLE;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control and serializer registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         enable_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         enable_q   <= enable_d;
      end
   end

   // FIFO storage; contents are qualified by the pointers, so no reset needed
   always_ff @(posedge clk_i) begin
      if (push_ok_c) fifo_mem_q[wr_ptr_q] <= WriteData_i[7:0];
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx: directed register accesses plus a serial-line
// monitor that decodes 8N1 frames and compares them against a queue of
// expected bytes filled when stores are issued.
module tb_mmio_uart_tx;

   localparam int unsigned CPB   = 4;
   localparam int unsigned DEPTH = 4;

   logic        clk;
   logic        reset_i;
   logic        MemWrite_i;
   logic        MemRead_i;
   logic [31:0] Address_i;
   logic [31:0] WriteData_i;
   logic        sel_o;
   logic [31:0] ReadData_o;
   logic        tx_o;

   int          n_tests;
   int          n_fail;
   int          cyc;
   logic        mon_en;
   logic        mon_prev;
   logic [7:0]  exp_q [$];
   int          start_q [$];

   mmio_uart_tx #(
      .BASE_ADDR    (32'h0000_1000),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset_i),
      .MemWrite_i  (MemWrite_i),
      .MemRead_i   (MemRead_i),
      .Address_i   (Address_i),
      .WriteData_i (WriteData_i),
      .sel_o       (sel_o),
      .ReadData_o  (ReadData_o),
      .tx_o        (tx_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Store; committed at the posedge that follows the negedge setup
   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, output logic s);
      @(negedge clk);
      Address_i   = a;
      WriteData_i = d;
      MemWrite_i  = 1'b1;
      #1 s = sel_o;
      @(posedge clk);
      #1 MemWrite_i = 1'b0;
   endtask

   // Store to TXDATA; the byte is expected on the line only if accepted
   task automatic tx_push(input logic [7:0] b, input logic accept);
      logic s;
      if (accept) exp_q.push_back(b);
      bus_wr(32'h0000_1000, 32'(b), s);
   endtask

   // Load; data is combinational so it is sampled within the same cycle
   task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic s);
      @(negedge clk);
      Address_i = a;
      MemRead_i = 1'b1;
      #1;
      d = ReadData_o;
      s = sel_o;
      MemRead_i = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] d;
      logic        s;
      bus_rd(a, d, s);
      check_eq(tag, d, exp);
   endtask

   function automatic logic exp_a5_tx(input int k);
      logic [7:0] b;
      b = 8'hA5;
      if (k < 2)  return 1'b1;
      if (k < 6)  return 1'b0;
      if (k < 38) return b[(k - 6) / 4];
      return 1'b1;
   endfunction

   // Line monitor: decodes each frame at bit centres and scores it
   initial begin
      logic [7:0] rx;
      logic [7:0] exp;
      mon_prev = 1'b1;
      forever begin
         @(negedge clk);
         if (mon_en && mon_prev === 1'b1 && tx_o === 1'b0) begin
            start_q.push_back(cyc);
            repeat (CPB / 2) @(negedge clk);
            check_eq("start_bit", 32'(tx_o), 32'h0);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               rx[i] = tx_o;
            end
            repeat (CPB) @(negedge clk);
            check_eq("stop_bit", 32'(tx_o), 32'h1);
            if (exp_q.size() == 0) begin
               check_eq("unexpected_frame", 32'(rx), 32'hFFFF_FFFF);
            end else begin
               exp = exp_q.pop_front();
               check_eq("frame_data", 32'(rx), 32'(exp));
            end
         end
         mon_prev = tx_o;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] d;
      logic        s;
      int          lows;
      int          k;

      n_tests     = 0;
      n_fail      = 0;
      cyc         = 0;
      mon_en      = 1'b0;
      reset_i     = 1'b1;
      MemWrite_i  = 1'b0;
      MemRead_i   = 1'b0;
      Address_i   = '0;
      WriteData_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_i = 1'b0;

      // Reset state
      check_eq("reset_tx", 32'(tx_o), 32'h1);
      rd_check("reset_status", 32'h0000_1004, 32'h0000_0004);
      rd_check("reset_ctrl",   32'h0000_1008, 32'h0000_0001);
      rd_check("txdata_read",  32'h0000_1000, 32'h0);
      rd_check("reserved_read", 32'h0000_100C, 32'h0);
      @(negedge clk);
      Address_i = 32'h0000_1004;
      MemRead_i = 1'b0;
      #1 check_eq("no_read_strobe", ReadData_o, 32'h0);
      mon_en = 1'b1;

      // Single frame with cycle-exact line and busy checks
      tx_push(8'hA5, 1'b1);
      for (k = 0; k <= 42; k++) begin
         @(negedge clk);
         Address_i = 32'h0000_1004;
         MemRead_i = 1'b1;
         #1;
         check_eq($sformatf("a5_tx_k%0d", k), 32'(tx_o), 32'(exp_a5_tx(k)));
         check_eq($sformatf("a5_busy_k%0d", k), 32'(ReadData_o[0]),
                  32'((k >= 1) && (k <= 40)));
         MemRead_i = 1'b0;
      end

      // Fill while disabled, overflow, clear it
      bus_wr(32'h0000_1008, 32'h0, s);
      for (int b = 1; b <= 5; b++) tx_push(8'(b), (b <= 4) ? 1'b1 : 1'b0);
      rd_check("status_full_ovf", 32'h0000_1004, 32'h0000_040A);
      check_eq("disabled_tx_idle", 32'(tx_o), 32'h1);
      bus_wr(32'h0000_1004, 32'h8, s);
      rd_check("status_ovf_clr", 32'h0000_1004, 32'h0000_0402);

      // Enable, then push into a full FIFO in the cycle of the first pop
      start_q.delete();
      bus_wr(32'h0000_1008, 32'h1, s);
      tx_push(8'h77, 1'b1);
      rd_check("status_push_pop", 32'h0000_1004, 32'h0000_0403);

      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
      check_eq("drain", 32'(exp_q.size()), 32'h0);
      check_eq("n_frames", 32'(start_q.size()), 32'd5);
      for (int i = 1; i < start_q.size(); i++)
         check_eq($sformatf("frame_gap%0d", i), 32'(start_q[i] - start_q[i-1]), 32'd41);
      repeat (10) @(negedge clk);
      rd_check("status_idle", 32'h0000_1004, 32'h0000_0004);

      // Reset during data bit 3 of a frame
      mon_en = 1'b0;
      tx_push(8'hF0, 1'b0);
      repeat (20) @(negedge clk);
      check_eq("pre_reset_bit3", 32'(tx_o), 32'h0);
      reset_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
      check_eq("post_reset_tx", 32'(tx_o), 32'h1);
      rd_check("post_reset_status", 32'h0000_1004, 32'h0000_0004);
      rd_check("post_reset_ctrl",   32'h0000_1008, 32'h0000_0001);
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx_o !== 1'b1) lows++;
      end
      check_eq("no_frame_after_reset", 32'(lows), 32'h0);
      mon_en = 1'b1;

      // Accesses outside the window
      bus_wr(32'h0000_2000, 32'hFF, s);
      check_eq("miss_wr_sel", 32'(s), 32'h0);
      bus_rd(32'h0000_2000, d, s);
      check_eq("miss_rd_sel",  32'(s), 32'h0);
      check_eq("miss_rd_data", d, 32'h0);
      bus_rd(32'h0000_1004, d, s);
      check_eq("hit_sel", 32'(s), 32'h1);
      check_eq("miss_count_unchanged", d, 32'h0000_0004);
      lows = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (tx_o !== 1'b1) lows++;
      end
      check_eq("miss_no_frame", 32'(lows), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter. It is the responder on the core's data-memory port (MemWrite/MemRead, ALU address, store data).
- Stores to its address window push bytes into a small FIFO. A serializer then shifts each byte out as 8N1 on tx_o.
- Loads from the window return status/control. The top level uses sel_o to steer ReadData_o into the load path instead of data_mem.

Parameters:
- BASE_ADDR, 32'h0000_1000, window base; window is BASE_ADDR[31:4] (16 bytes).
- CLKS_PER_BIT, 16, clk_i cycles per serial bit; legal range >= 2.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, >= 2.

Ports:
- clk_i  in  1  system clock; all state updates on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- MemWrite_i  in  1  store strobe from control unit.
- MemRead_i  in  1  load strobe from control unit.
- Address_i  in  32  byte address (ALU result).
- WriteData_i  in  32  store data (LSU output).
- sel_o  out  1  Address_i hits the window; combinational.
- ReadData_o  out  32  register read data; combinational.
- tx_o  out  1  serial line; idle high.

Behaviour:
- Decode: hit = (Address_i[31:4] == BASE_ADDR[31:4]). Register offset = Address_i[3:2]. Address_i[1:0] is ignored.
- Register map:
  - 0x0 TXDATA: write-only; reads return 0.
  - 0x4 STATUS: read-only except bit3.
  - 0x8 CTRL: read/write.
  - 0xC: reserved; reads return 0, writes ignored.
- Write access = hit & MemWrite_i, committed at the clock edge. Read access = hit & MemRead_i. ReadData_o is valid in the same cycle, with no wait state, matching the single-cycle core. ReadData_o = 0 when not (hit & MemRead_i).
- TXDATA write:
  - Pushes WriteData_i[7:0].
  - Accepted when count < FIFO_DEPTH, or when the serializer pops in the same cycle.
  - Otherwise the byte is dropped and STATUS.overflow is set.
- STATUS fields:
  - bit0 busy: state != IDLE.
  - bit1 full: count == FIFO_DEPTH.
  - bit2 empty: count == 0.
  - bit3 overflow: sticky; a write with WriteData_i[3]=1 clears it. If a clear and a new overflow occur in the same cycle, set wins.
  - bits[15:8]: count.
  - All other bits read 0.
- CTRL: bit0 enable, reset value 1.
  - Clearing enable lets the current frame finish and prevents new pops.
  - FIFO contents are retained while enable = 0.
- FIFO: circular buffer with read/write pointers that wrap modulo FIFO_DEPTH. count is width clog2(FIFO_DEPTH)+1. A simultaneous push and pop leaves count unchanged.
- Serializer FSM:
  - IDLE: tx_o=1. If enable & !empty: pop head into the shift register, clear the bit counter, go to START in the next cycle.
  - START: tx_o=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx_o=shift[0], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7 completes, go to STOP.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles, then IDLE.
- Frame timing: the start-bit falling edge appears one cycle after the pop. A frame occupies 10*CLKS_PER_BIT cycles plus 1 IDLE cycle before the next pop, so back-to-back frames have a one-cycle gap of high between them.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary; held at 0 in IDLE.
- Reset (any cycle, including mid-frame): the output register forces tx_o=1 on the next edge. State=IDLE, FIFO empty (pointers 0), overflow=0, enable=1, counters 0.
- tx_o is registered (glitch-free). sel_o and ReadData_o are combinational.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=0x1000):
- Reset, then read 0x1004 -> ReadData_o=0x0000_0004 (empty=1, count=0); tx_o=1; read 0x1008 -> 0x1.
- Store 0xA5 to 0x1000 -> start bit low for 4 cycles starting 2 cycles after the store edge. Data bits 1,0,1,0,0,1,0,1 (LSB first), 4 cycles each, then 4 cycles high. busy=1 throughout the frame.
- With enable=0, store 5 bytes 0x01..0x05 -> count=4, full=1, overflow=1, tx_o stays 1. Write 0x8 to 0x1004 -> overflow=0. Write 1 to 0x1008 -> 4 frames sent in order 0x01..0x04, each 41 cycles apart.
- With the FIFO full and the serializer popping in that cycle, store 0x77 -> accepted, count stays 4, overflow stays 0, and 0x77 is transmitted last.
- Assert reset_i for 1 cycle during bit 3 of a frame -> tx_o=1 from the next edge, STATUS=0x0000_0004, no further frame.
- Load/store to 0x2000 -> sel_o=0, ReadData_o=0, FIFO count unchanged.
